// File: rtl/cheat_engine_if.sv
// Bundle of every cheat_engine signal except clock and reset: the loader
// command port, the CPU read path, the freeze write port and status.
// The master side drives commands/bus/acks, the slave side is the engine.
interface cheat_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 32
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  logic                  enable;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [IDX_W-1:0]      cmd_slot;
  logic [1:0]            cmd_type;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_compare;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [DATA_WIDTH-1:0] cmd_mask;
  logic [IDX_W:0]        active_count;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  bus_strobe;
  logic                  ovr;
  logic [DATA_WIDTH-1:0] ovr_data;
  logic                  frame_tick;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_ack;
  logic                  busy;

  modport master (
    output enable, cmd_valid, cmd_op, cmd_slot, cmd_type, cmd_addr,
           cmd_compare, cmd_data, cmd_mask, bus_addr, bus_data, bus_strobe,
           frame_tick, wr_ack,
    input  cmd_ready, active_count, ovr, ovr_data, wr_req, wr_addr,
           wr_data, wr_mask, busy
  );

  modport slave (
    input  enable, cmd_valid, cmd_op, cmd_slot, cmd_type, cmd_addr,
           cmd_compare, cmd_data, cmd_mask, bus_addr, bus_data, bus_strobe,
           frame_tick, wr_ack,
    output cmd_ready, active_count, ovr, ovr_data, wr_req, wr_addr,
           wr_data, wr_mask, busy
  );
endinterface

// File: rtl/cheat_engine.sv
// Cheat / Game Genie engine: slot table loaded over a valid/ready command
// port, registered read-data patching with per-bit masks, and a per-frame
// sequencer that pushes freeze values into work RAM via req/ack.
module cheat_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 32
) (
  input  logic          clk,
  input  logic          reset,
  cheat_engine_if.slave bus_if
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [IDX_W:0]   SLOT_LIMIT = (IDX_W+1)'(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_PTR   = IDX_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REQ} state_t;

  // Slot table; valid bits are separate so clear-all is a single reset.
  logic [NUM_SLOTS-1:0]  slot_valid_reg;
  logic [1:0]            slot_type_reg    [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] slot_addr_reg    [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] slot_compare_reg [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] slot_data_reg    [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] slot_mask_reg    [NUM_SLOTS];
  logic [IDX_W:0]        active_count_reg;

  state_t                state_reg;
  logic [IDX_W-1:0]      ptr_reg;
  logic                  pending_reg;
  logic                  wr_req_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [DATA_WIDTH-1:0] wr_mask_reg;
  logic                  ovr_reg;
  logic [DATA_WIDTH-1:0] ovr_data_reg;

  logic                  cmd_fire;
  logic                  slot_in_range;
  logic                  do_write;
  logic                  do_clear;
  logic                  do_clear_all;
  logic [NUM_SLOTS-1:0]  hit;
  logic                  hit_any;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  last_slot;
  logic                  scan_freeze;

  // Commands are only taken in IDLE, so a scan always sees a frozen table.
  assign bus_if.cmd_ready = ~reset & (state_reg == IDLE);
  assign cmd_fire      = bus_if.cmd_valid & bus_if.cmd_ready;
  assign slot_in_range = ({1'b0, bus_if.cmd_slot} < SLOT_LIMIT);
  assign do_write      = cmd_fire && bus_if.cmd_op == 2'b00 && slot_in_range && bus_if.cmd_type != 2'b11;
  assign do_clear      = cmd_fire && bus_if.cmd_op == 2'b01 && slot_in_range;
  assign do_clear_all  = cmd_fire && bus_if.cmd_op == 2'b10;

  // Slot payload fields: plain storage, meaningful only while valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      slot_type_reg[bus_if.cmd_slot]    <= bus_if.cmd_type;
      slot_addr_reg[bus_if.cmd_slot]    <= bus_if.cmd_addr;
      slot_compare_reg[bus_if.cmd_slot] <= bus_if.cmd_compare;
      slot_data_reg[bus_if.cmd_slot]    <= bus_if.cmd_data;
      slot_mask_reg[bus_if.cmd_slot]    <= bus_if.cmd_mask;
    end
  end

  // Valid bits and the live-slot counter move together.
  always_ff @(posedge clk) begin
    if (reset || do_clear_all) begin
      slot_valid_reg   <= '0;
      active_count_reg <= '0;
    end else if (do_write) begin
      slot_valid_reg[bus_if.cmd_slot] <= 1'b1;
      if (!slot_valid_reg[bus_if.cmd_slot])
        active_count_reg <= active_count_reg + 1'b1;
    end else if (do_clear && slot_valid_reg[bus_if.cmd_slot]) begin
      slot_valid_reg[bus_if.cmd_slot] <= 1'b0;
      active_count_reg <= active_count_reg - 1'b1;
    end
  end

  // Per-slot match; freeze and reserved types never hit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
      assign hit[gi] = slot_valid_reg[gi] &&
                       slot_addr_reg[gi] == bus_if.bus_addr &&
                       (slot_type_reg[gi] == 2'b00 ||
                        (slot_type_reg[gi] == 2'b01 && slot_compare_reg[gi] == bus_if.bus_data));
    end
  endgenerate

  // Priority select: walking downward leaves the lowest-index hit in place.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any  = 1'b1;
        hit_data = (bus_if.bus_data & ~slot_mask_reg[i]) | (slot_data_reg[i] & slot_mask_reg[i]);
      end
    end
  end

  // Registered override: one cycle of ovr per sampled strobe.
  always_ff @(posedge clk) begin
    if (reset || !(bus_if.bus_strobe && bus_if.enable && hit_any)) begin
      ovr_reg      <= 1'b0;
      ovr_data_reg <= '0;
    end else begin
      ovr_reg      <= 1'b1;
      ovr_data_reg <= hit_data;
    end
  end

  assign last_slot   = (ptr_reg == LAST_PTR);
  assign scan_freeze = slot_valid_reg[ptr_reg] && slot_type_reg[ptr_reg] == 2'b10;

  // Freeze sequencer: walk every slot once per frame, one write per freeze slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      pending_reg <= 1'b0;
      wr_req_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_mask_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if ((bus_if.frame_tick || pending_reg) && bus_if.enable) begin
            state_reg   <= SCAN;
            ptr_reg     <= '0;
            pending_reg <= 1'b0;
          end
        end
        SCAN: begin
          if (bus_if.frame_tick) pending_reg <= 1'b1;
          if (!bus_if.enable) begin
            state_reg <= IDLE;
          end else if (scan_freeze) begin
            state_reg   <= REQ;
            wr_req_reg  <= 1'b1;
            wr_addr_reg <= slot_addr_reg[ptr_reg];
            wr_data_reg <= slot_data_reg[ptr_reg];
            wr_mask_reg <= slot_mask_reg[ptr_reg];
          end else if (last_slot) begin
            state_reg <= IDLE;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        REQ: begin
          if (bus_if.frame_tick) pending_reg <= 1'b1;
          if (bus_if.wr_ack) begin
            wr_req_reg  <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            wr_mask_reg <= '0;
            if (last_slot || !bus_if.enable) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= SCAN;
              ptr_reg   <= ptr_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus_if.active_count = active_count_reg;
  assign bus_if.ovr          = ovr_reg;
  assign bus_if.ovr_data     = ovr_data_reg;
  assign bus_if.wr_req       = wr_req_reg;
  assign bus_if.wr_addr      = wr_addr_reg;
  assign bus_if.wr_data      = wr_data_reg;
  assign bus_if.wr_mask      = wr_mask_reg;
  assign bus_if.busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_cheat_engine.sv
// Directed bench for cheat_engine: table commands, patch lookups, freeze
// sequencing with req/ack, enable gating and reset behaviour.
module tb_cheat_engine;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NS = 32;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  cheat_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLOTS(NS)) bus_if ();

  cheat_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLOTS(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus_if)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int slot, input logic [1:0] typ,
                          input logic [15:0] addr, input logic [7:0] cmp,
                          input logic [7:0] dat, input logic [7:0] msk, input logic tick);
    bus_if.cmd_op      = op;
    bus_if.cmd_slot    = 5'(slot);
    bus_if.cmd_type    = typ;
    bus_if.cmd_addr    = addr;
    bus_if.cmd_compare = cmp;
    bus_if.cmd_data    = dat;
    bus_if.cmd_mask    = msk;
    bus_if.cmd_valid   = 1'b1;
    bus_if.frame_tick  = tick;
    chk("cmd_ready", 32'(bus_if.cmd_ready), 1);
    step();
    bus_if.cmd_valid  = 1'b0;
    bus_if.frame_tick = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [15:0] addr, input logic [7:0] data,
                        input logic exp_ovr, input logic [7:0] exp_data);
    bus_if.bus_addr   = addr;
    bus_if.bus_data   = data;
    bus_if.bus_strobe = 1'b1;
    step();
    bus_if.bus_strobe = 1'b0;
    chk({tag, ".ovr"}, 32'(bus_if.ovr), 32'(exp_ovr));
    chk({tag, ".data"}, 32'(bus_if.ovr_data), 32'(exp_data));
    $display("lookup %s addr=%h data=%h ovr=%0d ovr_data=%h", tag, addr, data, bus_if.ovr, bus_if.ovr_data);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus_if.wr_req !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, ".req_seen"}, 32'(bus_if.wr_req), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus_if.busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, ".idle"}, 32'(bus_if.busy), 0);
  endtask

  // Serve one freeze write: ack 3 cycles after wr_req, optionally pulsing
  // two extra frame ticks while the request is outstanding.
  task automatic serve_write(input string tag, input logic [15:0] exp_addr,
                             input logic [7:0] exp_data, input logic [7:0] exp_mask,
                             input logic pulse);
    wait_req(tag);
    chk({tag, ".addr"}, 32'(bus_if.wr_addr), 32'(exp_addr));
    chk({tag, ".wdata"}, 32'(bus_if.wr_data), 32'(exp_data));
    chk({tag, ".mask"}, 32'(bus_if.wr_mask), 32'(exp_mask));
    for (int i = 0; i < 3; i++) begin
      bus_if.frame_tick = pulse && (i != 1);
      step();
      bus_if.frame_tick = 1'b0;
    end
    chk({tag, ".held"}, 32'(bus_if.wr_req), 1);
    chk({tag, ".addr_held"}, 32'(bus_if.wr_addr), 32'(exp_addr));
    chk({tag, ".cmd_ready"}, 32'(bus_if.cmd_ready), 0);
    bus_if.wr_ack = 1'b1;
    step();
    bus_if.wr_ack = 1'b0;
    chk({tag, ".req_drop"}, 32'(bus_if.wr_req), 0);
    $display("write %s addr=%h data=%h mask=%h", tag, exp_addr, exp_data, exp_mask);
  endtask

  task automatic watch_no_req(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus_if.wr_req === 1'b1) seen++;
    end
    chk({tag, ".no_req"}, 32'(seen), 0);
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus_if.enable = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op = 2'b11;
    bus_if.cmd_slot = '0;
    bus_if.cmd_type = 2'b00;
    bus_if.cmd_addr = '0;
    bus_if.cmd_compare = '0;
    bus_if.cmd_data = '0;
    bus_if.cmd_mask = '0;
    bus_if.bus_addr = '0;
    bus_if.bus_data = '0;
    bus_if.bus_strobe = 1'b0;
    bus_if.frame_tick = 1'b0;
    bus_if.wr_ack = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst.cmd_ready", 32'(bus_if.cmd_ready), 0);
    chk("rst.count", 32'(bus_if.active_count), 0);
    chk("rst.ovr", 32'(bus_if.ovr), 0);
    chk("rst.wr_req", 32'(bus_if.wr_req), 0);
    chk("rst.busy", 32'(bus_if.busy), 0);
    reset = 1'b0;
    bus_if.enable = 1'b1;
    #1;
    chk("post_rst.cmd_ready", 32'(bus_if.cmd_ready), 1);

    // Substitute code
    send_cmd(2'b00, 3, 2'b00, 16'h8123, 8'h00, 8'hA5, 8'hFF, 1'b0);
    chk("sub.count", 32'(bus_if.active_count), 1);
    lookup("sub.hit", 16'h8123, 8'h11, 1'b1, 8'hA5);
    step();
    chk("sub.one_cycle", 32'(bus_if.ovr), 0);
    lookup("sub.miss", 16'h8124, 8'h11, 1'b0, 8'h00);

    // Compare-substitute code
    send_cmd(2'b00, 6, 2'b01, 16'h4000, 8'h31, 8'h0A, 8'h0F, 1'b0);
    chk("cmp.count", 32'(bus_if.active_count), 2);
    lookup("cmp.hit", 16'h4000, 8'h31, 1'b1, 8'h3A);
    lookup("cmp.miss", 16'h4000, 8'h32, 1'b0, 8'h00);

    // Priority between two slots on one address
    send_cmd(2'b00, 2, 2'b00, 16'h5000, 8'h00, 8'h22, 8'hFF, 1'b0);
    send_cmd(2'b00, 5, 2'b00, 16'h5000, 8'h00, 8'h55, 8'hFF, 1'b0);
    chk("prio.count", 32'(bus_if.active_count), 4);
    lookup("prio.low", 16'h5000, 8'h99, 1'b1, 8'h22);
    send_cmd(2'b01, 2, 2'b00, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("clr.count", 32'(bus_if.active_count), 3);
    lookup("prio.next", 16'h5000, 8'h99, 1'b1, 8'h55);
    send_cmd(2'b01, 2, 2'b00, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("clr_invalid.count", 32'(bus_if.active_count), 3);
    send_cmd(2'b00, 5, 2'b00, 16'h5000, 8'h00, 8'h55, 8'hF0, 1'b0);
    chk("rewrite.count", 32'(bus_if.active_count), 3);
    lookup("mask.partial", 16'h5000, 8'h0A, 1'b1, 8'h5A);
    send_cmd(2'b00, 7, 2'b11, 16'h6000, 8'h00, 8'h77, 8'hFF, 1'b0);
    chk("reserved.count", 32'(bus_if.active_count), 3);
    lookup("reserved.miss", 16'h6000, 8'h00, 1'b0, 8'h00);
    bus_if.enable = 1'b0;
    lookup("enable_low", 16'h8123, 8'h11, 1'b0, 8'h00);
    bus_if.enable = 1'b1;

    // Freeze slots 1 and 4, with extra ticks mid-scan giving one rerun
    send_cmd(2'b00, 1, 2'b10, 16'h0300, 8'h00, 8'h09, 8'hFF, 1'b0);
    send_cmd(2'b00, 4, 2'b10, 16'h0301, 8'h00, 8'h63, 8'hFF, 1'b0);
    chk("frz.count", 32'(bus_if.active_count), 5);
    lookup("frz.no_ovr", 16'h0300, 8'h00, 1'b0, 8'h00);
    bus_if.frame_tick = 1'b1;
    step();
    bus_if.frame_tick = 1'b0;
    chk("frz.busy", 32'(bus_if.busy), 1);
    chk("frz.scan_cmd_ready", 32'(bus_if.cmd_ready), 0);
    serve_write("frz.s1", 16'h0300, 8'h09, 8'hFF, 1'b1);
    serve_write("frz.s4", 16'h0301, 8'h63, 8'hFF, 1'b0);
    serve_write("rerun.s1", 16'h0300, 8'h09, 8'hFF, 1'b0);
    serve_write("rerun.s4", 16'h0301, 8'h63, 8'hFF, 1'b0);
    wait_idle("rerun");
    watch_no_req("rerun.once", 60);
    chk("rerun.busy_end", 32'(bus_if.busy), 0);

    // Enable dropped during REQ
    bus_if.frame_tick = 1'b1;
    step();
    bus_if.frame_tick = 1'b0;
    wait_req("en");
    bus_if.enable = 1'b0;
    step(); step();
    chk("en.held", 32'(bus_if.wr_req), 1);
    chk("en.addr", 32'(bus_if.wr_addr), 32'h0300);
    bus_if.wr_ack = 1'b1;
    step();
    bus_if.wr_ack = 1'b0;
    chk("en.req_drop", 32'(bus_if.wr_req), 0);
    chk("en.idle", 32'(bus_if.busy), 0);
    bus_if.frame_tick = 1'b1;
    step();
    bus_if.frame_tick = 1'b0;
    watch_no_req("en.off", 40);
    bus_if.enable = 1'b1;
    step();
    chk("en.no_pending", 32'(bus_if.busy), 0);
    $display("enable-low scan ended after one write");

    // Reset during REQ drops the write
    bus_if.frame_tick = 1'b1;
    step();
    bus_if.frame_tick = 1'b0;
    wait_req("rq");
    reset = 1'b1;
    step();
    chk("rq.wr_req", 32'(bus_if.wr_req), 0);
    chk("rq.busy", 32'(bus_if.busy), 0);
    chk("rq.cmd_ready", 32'(bus_if.cmd_ready), 0);
    chk("rq.count", 32'(bus_if.active_count), 0);
    reset = 1'b0;
    #1;
    chk("rq.ready_after", 32'(bus_if.cmd_ready), 1);

    // Fill every slot, then clear all
    for (int i = 0; i < NS; i++) begin
      logic [7:0] d;
      d = 8'(i) ^ 8'hC0;
      send_cmd(2'b00, i, 2'b00, 16'h1000 + 16'(i), 8'h00, d, 8'hFF, 1'b0);
    end
    chk("full.count", 32'(bus_if.active_count), 32);
    lookup("full.s5", 16'h1005, 8'h00, 1'b1, 8'hC5);
    lookup("full.s31", 16'h101F, 8'h00, 1'b1, 8'hDF);
    send_cmd(2'b10, 0, 2'b00, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("clrall.count", 32'(bus_if.active_count), 0);
    lookup("clrall.s0", 16'h1000, 8'h00, 1'b0, 8'h00);
    lookup("clrall.s31", 16'h101F, 8'h00, 1'b0, 8'h00);
    lookup("clrall.old", 16'h8123, 8'h11, 1'b0, 8'h00);

    // Empty scan length
    bus_if.frame_tick = 1'b1;
    step();
    bus_if.frame_tick = 1'b0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("empty.cycles", 32'(n), 32);
    chk("empty.no_req", 32'(bus_if.wr_req), 0);
    $display("empty scan busy cycles=%0d", n);

    // Command and tick together: scan sees the new freeze slot at slot 0
    send_cmd(2'b00, 0, 2'b10, 16'h0400, 8'h00, 8'h7E, 8'h3C, 1'b1);
    chk("same.busy", 32'(bus_if.busy), 1);
    chk("same.no_req_yet", 32'(bus_if.wr_req), 0);
    step();
    chk("same.req", 32'(bus_if.wr_req), 1);
    chk("same.addr", 32'(bus_if.wr_addr), 32'h0400);
    chk("same.wdata", 32'(bus_if.wr_data), 32'h7E);
    chk("same.mask", 32'(bus_if.wr_mask), 32'h3C);
    bus_if.wr_ack = 1'b1;
    step();
    bus_if.wr_ack = 1'b0;
    chk("same.req_drop", 32'(bus_if.wr_req), 0);
    wait_idle("same");
    $display("same-cycle command+tick write served");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
